rx_demux: RTL and testbench
===========================

RX_DEMUX -- requirements
Module: rx_demux

Interface
REQ-001 SHALL have parameter STP, default 8'hFB, meaning TLP start framing symbol.
REQ-002 SHALL have parameter SDP, default 8'h5C, meaning DLLP start framing symbol.
REQ-003 SHALL have parameter END, default 8'hFD, meaning good-end framing symbol.
REQ-004 SHALL have parameter EDB, default 8'hFE, meaning nullified-end framing symbol.
REQ-005 SHALL have parameter MAX_TLP, default 64, meaning maximum TLP payload bytes.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port fromUnstrip, input, 8 bits: one byte per clock from the unstriping stage.
REQ-009 SHALL have ports tlp_data, output, 8 bits, and tlp_valid, output, 1 bit: the TLP payload byte and its qualifier.
REQ-010 SHALL have ports tlp_sop and tlp_eop, outputs, 1 bit each: first and last TLP payload byte markers.
REQ-011 SHALL have ports dllp_data, output, 8 bits, and dllp_valid, output, 1 bit: the DLLP payload byte and its qualifier.
REQ-012 SHALL have ports dllp_sop and dllp_eop, outputs, 1 bit each: first and last DLLP payload byte markers.
REQ-013 SHALL have port nullify, output, 1 bit: pulses with eop when a packet ends in EDB.
REQ-014 SHALL have port pkt_err, output, 1 bit: one-cycle framing or length error pulse.
REQ-015 SHALL have ports tlp_cnt and dllp_cnt, outputs, 8 bits each: good-packet counters that wrap.

Function
REQ-016 SHALL implement FSM states IDLE, TLP, DLLP.
REQ-017 In IDLE: STP -> TLP; SDP -> DLLP; any other byte (IDL, SKP, COM, PAD, data) ignored; no output.
REQ-018 Framing symbols (STP, SDP, END, EDB) SHALL never appear on any data output.
REQ-019 In TLP/DLLP, each payload byte is captured into a one-byte hold register and emitted at the edge where the next symbol is sampled (valid for one cycle after that edge).
REQ-020 Emitted byte SHALL carry sop=1 if it is the first payload byte of the packet.
REQ-021 On END: emit held byte with eop=1, return to IDLE; increment the matching counter if no error (8-bit wrap, 255 -> 0).
REQ-022 On EDB: emit held byte with eop=1 and nullify=1, return to IDLE; counter not incremented.
REQ-023 Payload byte counter SHALL be 7 bits, clear on packet start, increment per captured byte.
REQ-024 DLLP ending (END) with payload count != 6 SHALL assert pkt_err with eop; counter not incremented.
REQ-025 Capturing TLP byte number MAX_TLP+1 SHALL emit held byte with eop=1 and pkt_err=1, discard the new byte, and go to IDLE.
REQ-026 END/EDB immediately after STP/SDP (empty packet) SHALL pulse pkt_err only; no valid; IDLE.
REQ-027 STP/SDP received inside a packet SHALL emit held byte with eop=1 and pkt_err=1, then start the new packet (TLP/DLLP) in the same cycle.
REQ-028 A single-byte packet SHALL emit one byte with sop=1 and eop=1 together.
REQ-029 The valid, sop, eop, nullify and pkt_err outputs SHALL be registered, deasserted by default each cycle, and never asserted on both TLP and DLLP channels in the same cycle.
REQ-030 Data outputs SHALL hold their last value when valid=0.

Reset
REQ-031 reset_L=0 SHALL immediately force state=IDLE, hold register, byte counter, all data outputs, all flags, tlp_cnt and dllp_cnt to 0.
REQ-032 Reset mid-packet SHALL discard the partial packet; after release, bytes are ignored until STP/SDP.
REQ-033 The first edge after reset_L rises SHALL be treated as an IDLE sample.

Verification
REQ-034 STP,11,22,33,END -> tlp_valid 3 cycles: 11 (sop), 22, 33 (eop); tlp_cnt=1; pkt_err=0.
REQ-035 SDP,A0..A5,END -> dllp bytes A0 (sop) .. A5 (eop), dllp_cnt=1; SDP,A0..A4,END -> A4 with eop and pkt_err=1, dllp_cnt unchanged.
REQ-036 STP,44,EDB -> tlp_data=44 with sop, eop and nullify=1 together; tlp_cnt unchanged; STP,END -> pkt_err pulse only.
REQ-037 STP followed by 65 bytes 00..40 -> 64 bytes out, byte 3F with eop and pkt_err; 40 dropped; IDLE.
REQ-038 STP,55,SDP,B0..B5,END -> 55 with sop, eop and pkt_err; then a good DLLP; dllp_cnt=1.
REQ-039 reset_L pulsed low mid-TLP -> all outputs 0 asynchronously; later 55,END -> no output; 255 good TLPs then 1 more -> tlp_cnt wraps to 0.

Source files
------------

// File: rtl/rx_demux.sv
// Receive-side demultiplexer: strips STP/SDP/END/EDB framing from the unstriped
// byte stream and steers payload onto separate TLP and DLLP channels.
module rx_demux #(
  parameter logic [7:0]  STP     = 8'hFB,
  parameter logic [7:0]  SDP     = 8'h5C,
  parameter logic [7:0]  END     = 8'hFD,
  parameter logic [7:0]  EDB     = 8'hFE,
  parameter int unsigned MAX_TLP = 64
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] fromUnstrip,
  output logic [7:0] tlp_data,
  output logic       tlp_valid,
  output logic       tlp_sop,
  output logic       tlp_eop,
  output logic [7:0] dllp_data,
  output logic       dllp_valid,
  output logic       dllp_sop,
  output logic       dllp_eop,
  output logic       nullify,
  output logic       pkt_err,
  output logic [7:0] tlp_cnt,
  output logic [7:0] dllp_cnt
);

  typedef enum logic [1:0] {IDLE, TLP, DLLP} state_t;

  state_t     state, state_nx;
  logic [7:0] hold;
  logic [6:0] cnt;

  logic is_stp, is_sdp, is_end, is_edb, is_frame, has_byte, overflow;
  logic emit, emit_eop, err, nul, capture, good;

  assign is_stp   = (fromUnstrip == STP);
  assign is_sdp   = (fromUnstrip == SDP);
  assign is_end   = (fromUnstrip == END);
  assign is_edb   = (fromUnstrip == EDB);
  assign is_frame = is_stp | is_sdp | is_end | is_edb;
  // The hold register is occupied exactly when at least one byte was captured.
  assign has_byte = (cnt != '0);
  assign overflow = (state == TLP) && !is_frame && (32'(cnt) == MAX_TLP);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (is_stp)                 state_nx = TLP;
    else if (is_sdp)            state_nx = DLLP;
    else if (state != IDLE) begin
      if (is_end || is_edb || overflow) state_nx = IDLE;
    end
  end

  always_comb begin
    emit     = 1'b0;
    emit_eop = 1'b0;
    err      = 1'b0;
    nul      = 1'b0;
    capture  = 1'b0;
    good     = 1'b0;
    if (state != IDLE) begin
      if (is_stp || is_sdp) begin
        emit     = has_byte;
        emit_eop = 1'b1;
        err      = 1'b1;
      end else if (is_end) begin
        if (!has_byte) begin
          err = 1'b1;
        end else begin
          emit     = 1'b1;
          emit_eop = 1'b1;
          if (state == DLLP && cnt != 7'd6) err  = 1'b1;
          else                              good = 1'b1;
        end
      end else if (is_edb) begin
        if (!has_byte) begin
          err = 1'b1;
        end else begin
          emit     = 1'b1;
          emit_eop = 1'b1;
          nul      = 1'b1;
        end
      end else if (overflow) begin
        emit     = 1'b1;
        emit_eop = 1'b1;
        err      = 1'b1;
      end else begin
        emit    = has_byte;
        capture = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      hold <= '0;
      cnt  <= '0;
    end else begin
      if (capture) hold <= fromUnstrip;
      if (is_stp || is_sdp)      cnt <= '0;
      else if (capture)          cnt <= cnt + 7'd1;
      else if (state_nx == IDLE) cnt <= '0;
    end
  end

  // The emitted byte is byte number cnt of the packet, so sop is simply cnt==1.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      tlp_data   <= '0;
      tlp_valid  <= 1'b0;
      tlp_sop    <= 1'b0;
      tlp_eop    <= 1'b0;
      dllp_data  <= '0;
      dllp_valid <= 1'b0;
      dllp_sop   <= 1'b0;
      dllp_eop   <= 1'b0;
      nullify    <= 1'b0;
      pkt_err    <= 1'b0;
      tlp_cnt    <= '0;
      dllp_cnt   <= '0;
    end else begin
      tlp_valid  <= emit && (state == TLP);
      tlp_sop    <= emit && (state == TLP) && (cnt == 7'd1);
      tlp_eop    <= emit && emit_eop && (state == TLP);
      dllp_valid <= emit && (state == DLLP);
      dllp_sop   <= emit && (state == DLLP) && (cnt == 7'd1);
      dllp_eop   <= emit && emit_eop && (state == DLLP);
      nullify    <= nul;
      pkt_err    <= err;
      if (emit && state == TLP)  tlp_data  <= hold;
      if (emit && state == DLLP) dllp_data <= hold;
      if (good && state == TLP)  tlp_cnt   <= tlp_cnt + 8'd1;
      if (good && state == DLLP) dllp_cnt  <= dllp_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_demux.sv
// Directed bench for rx_demux: framed byte sequences with hand-computed
// per-channel output records and counter values.
module tb_rx_demux;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] fromUnstrip = 8'h00;
  logic [7:0] tlp_data, dllp_data, tlp_cnt, dllp_cnt;
  logic       tlp_valid, tlp_sop, tlp_eop;
  logic       dllp_valid, dllp_sop, dllp_eop;
  logic       nullify, pkt_err;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned err_only = 0;
  int unsigned both = 0;
  logic [11:0] tq[$];
  logic [11:0] dq[$];

  rx_demux #(.STP(8'hFB), .SDP(8'h5C), .END(8'hFD), .EDB(8'hFE), .MAX_TLP(64)) dut (
    .clk(clk), .reset_L(reset_L), .fromUnstrip(fromUnstrip),
    .tlp_data(tlp_data), .tlp_valid(tlp_valid), .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
    .dllp_data(dllp_data), .dllp_valid(dllp_valid), .dllp_sop(dllp_sop), .dllp_eop(dllp_eop),
    .nullify(nullify), .pkt_err(pkt_err), .tlp_cnt(tlp_cnt), .dllp_cnt(dllp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ev(input logic sop, input logic eop, input logic nul,
                                     input logic err, input logic [7:0] d);
    return {sop, eop, nul, err, d};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    fromUnstrip = b;
    @(posedge clk);
    #1;
    if (tlp_valid)  tq.push_back({tlp_sop, tlp_eop, nullify, pkt_err, tlp_data});
    if (dllp_valid) dq.push_back({dllp_sop, dllp_eop, nullify, pkt_err, dllp_data});
    if (pkt_err && !tlp_valid && !dllp_valid) err_only++;
    if (tlp_valid && dllp_valid) both++;
  endtask

  task automatic clear_log();
    tq.delete();
    dq.delete();
    err_only = 0;
  endtask

  initial begin
    #1;
    check("reset_outs", {tlp_data, tlp_valid, tlp_sop, tlp_eop, dllp_data, dllp_valid,
                         dllp_sop, dllp_eop, nullify, pkt_err, tlp_cnt, dllp_cnt}, '0);
    #20;
    @(negedge clk);
    reset_L = 1'b1;

    // good 3-byte TLP
    clear_log();
    send(8'hFB); send(8'h11); send(8'h22); send(8'h33); send(8'hFD);
    check("tlp3_n", tq.size(), 3);
    check("tlp3_b0", tq[0], ev(1, 0, 0, 0, 8'h11));
    check("tlp3_b1", tq[1], ev(0, 0, 0, 0, 8'h22));
    check("tlp3_b2", tq[2], ev(0, 1, 0, 0, 8'h33));
    check("tlp3_cnt", tlp_cnt, 1);
    check("tlp3_dq", dq.size(), 0);
    send(8'h00);
    check("hold_data", {tlp_valid, tlp_data}, {1'b0, 8'h33});

    // good 6-byte DLLP
    clear_log();
    send(8'h5C);
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i));
    send(8'hFD);
    check("dllp6_n", dq.size(), 6);
    check("dllp6_b0", dq[0], ev(1, 0, 0, 0, 8'hA0));
    check("dllp6_b3", dq[3], ev(0, 0, 0, 0, 8'hA3));
    check("dllp6_b5", dq[5], ev(0, 1, 0, 0, 8'hA5));
    check("dllp6_cnt", dllp_cnt, 1);

    // short DLLP
    clear_log();
    send(8'h5C);
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
    send(8'hFD);
    check("dllp5_n", dq.size(), 5);
    check("dllp5_last", dq[4], ev(0, 1, 0, 1, 8'hA4));
    check("dllp5_cnt", dllp_cnt, 1);

    // nullified single-byte TLP
    clear_log();
    send(8'hFB); send(8'h44); send(8'hFE);
    check("edb_n", tq.size(), 1);
    check("edb_b0", tq[0], ev(1, 1, 1, 0, 8'h44));
    check("edb_cnt", tlp_cnt, 1);

    // empty packet
    clear_log();
    send(8'hFB); send(8'hFD);
    check("empty_tq", tq.size(), 0);
    check("empty_err", err_only, 1);

    // oversize TLP: 65 bytes 00..40
    clear_log();
    send(8'hFB);
    for (int i = 0; i <= 64; i++) send(8'(i));
    send(8'hFD);
    check("ovf_n", tq.size(), 64);
    check("ovf_b0", tq[0], ev(1, 0, 0, 0, 8'h00));
    check("ovf_last", tq[63], ev(0, 1, 0, 1, 8'h3F));
    check("ovf_erronly", err_only, 0);
    check("ovf_cnt", tlp_cnt, 1);

    // STP interrupted by SDP, then a good DLLP
    clear_log();
    send(8'hFB); send(8'h55); send(8'h5C);
    for (int i = 0; i < 6; i++) send(8'hB0 + 8'(i));
    send(8'hFD);
    check("intr_tn", tq.size(), 1);
    check("intr_t0", tq[0], ev(1, 1, 0, 1, 8'h55));
    check("intr_dn", dq.size(), 6);
    check("intr_d0", dq[0], ev(1, 0, 0, 0, 8'hB0));
    check("intr_d5", dq[5], ev(0, 1, 0, 0, 8'hB5));
    check("intr_dcnt", dllp_cnt, 2);
    check("intr_tcnt", tlp_cnt, 1);

    // asynchronous reset mid-TLP (tlp_valid is high for byte 11 at this point)
    clear_log();
    send(8'hFB); send(8'h11); send(8'h22);
    check("pre_rst_v", tlp_valid, 1);
    #2;
    reset_L = 1'b0;
    #1;
    check("async_rst", {tlp_data, tlp_valid, tlp_sop, tlp_eop, dllp_data, dllp_valid,
                        dllp_sop, dllp_eop, nullify, pkt_err, tlp_cnt, dllp_cnt}, '0);
    @(negedge clk);
    reset_L = 1'b1;
    clear_log();
    send(8'h55); send(8'hFD);
    check("post_rst_tq", tq.size(), 0);
    check("post_rst_err", err_only, 0);

    // counter wrap
    for (int k = 0; k < 255; k++) begin
      send(8'hFB); send(8'h01); send(8'hFD);
    end
    check("cnt_255", tlp_cnt, 255);
    send(8'hFB); send(8'h01); send(8'hFD);
    check("cnt_wrap", tlp_cnt, 0);
    check("dcnt_keep", dllp_cnt, 0);

    check("excl_valid", both, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
